// File: rtl/doc_uart_tx.sv
// doc_uart_tx: streams the 512-cell document RAM out as 8N1 UART and pulses done after the last stop bit.
// Optional DOC_UART_NEWLINE_EN appends CR LF after every 32-cell row.
module doc_uart_tx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD,
    parameter int DOC_DEPTH  = 512
`ifdef DOC_UART_NEWLINE_EN
    ,
    parameter int ROW_LEN    = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_baud, r_shift, w_byte;
    logic [2:0] r_bit;
    logic [8:0] r_idx, w_idx_nxt;
    logic       w_bit_end, w_last, w_extra, w_rd_en_nxt;
    assign w_bit_end = r_baud == 8'(BIT_CYCLES - 1);
    assign w_last    = r_idx == 9'(DOC_DEPTH - 1);
    assign tx        = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
`ifdef DOC_UART_NEWLINE_EN
    logic [1:0] r_nl, w_nl_nxt;
    assign w_extra     = r_idx[4:0] == 5'(ROW_LEN - 1) && r_nl != 2'd2;
    assign w_byte      = r_nl == 2'd1 ? 8'h0D : r_nl == 2'd2 ? 8'h0A : rd_data == 8'h00 ? 8'h20 : rd_data;
    assign w_nl_nxt    = (r_state == STOP && w_bit_end) ? (w_extra ? r_nl + 2'd1 : 2'd0) : r_nl;
    assign w_rd_en_nxt = w_state_nxt == FETCH && w_nl_nxt == 2'd0;
    // CR/LF phase: 0 = document byte, 1 = CR frame, 2 = LF frame
    always_ff @(posedge clk) begin
        r_nl <= rst ? 2'd0 : w_nl_nxt;
    end
`else
    assign w_extra     = 1'b0;
    assign w_byte      = rd_data == 8'h00 ? 8'h20 : rd_data;
    assign w_rd_en_nxt = w_state_nxt == FETCH;
`endif
    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_nxt;
    end
    // next state and next byte index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                w_state_nxt = start ? FETCH : IDLE;
                w_idx_nxt   = start ? 9'd0 : r_idx;
            end
            FETCH: w_state_nxt = START;
            START: w_state_nxt = w_bit_end ? DATA : START;
            DATA:  w_state_nxt = (w_bit_end && r_bit == 3'd7) ? STOP : DATA;
            STOP: if (w_bit_end) begin
                w_state_nxt = (w_last && !w_extra) ? DONE : FETCH;
                w_idx_nxt   = (w_last || w_extra) ? r_idx : r_idx + 9'd1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // baud/bit counters, shift register and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_idx   <= 9'd0;
            rd_en   <= 1'b0;
            rd_addr <= 9'd0;
        end else begin
            r_baud  <= (r_state inside {START, DATA, STOP} && !w_bit_end) ? r_baud + 8'd1 : 8'd0;
            r_bit   <= r_state == DATA ? r_bit + {2'b00, w_bit_end} : 3'd0;
            r_shift <= r_state == FETCH ? w_byte : (r_state == DATA && w_bit_end) ? {1'b0, r_shift[7:1]} : r_shift;
            r_idx   <= w_idx_nxt;
            rd_en   <= w_rd_en_nxt;
            rd_addr <= w_rd_en_nxt ? w_idx_nxt : rd_addr;
        end
    end
endmodule

// File: tb/tb_doc_uart_tx.sv
// tb_doc_uart_tx: directed bench for doc_uart_tx with a behavioural document RAM and UART receiver.
module tb_doc_uart_tx;
    localparam int B = 8;
`ifdef DOC_UART_NEWLINE_EN
    localparam int NBYTES = 576;
`else
    localparam int NBYTES = 512;
`endif
    localparam int EXP_DONE = NBYTES * (1 + 10 * B) + 1;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       rd_en, tx, busy, done;
    logic [8:0] rd_addr;
    logic [7:0] rd_data, mon_v;
    logic [7:0] mem [512];
    logic [7:0] q[$], exp_q[$];
    int         n_vec = 0, n_bad = 0, frame_err = 0;
    int         bad, dn, nq;
    assign rd_data = mem[rd_addr];
    always #20 clk = ~clk;
    doc_uart_tx #(.CLK_FREQ(25000000), .BAUD(3125000)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // UART receiver sampling mid-bit on the falling clock edge
    initial forever begin
        @(negedge clk);
        if (tx === 1'b0) begin
            repeat (B / 2) @(negedge clk);
            if (tx !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++) begin
                repeat (B) @(negedge clk);
                mon_v[k] = tx;
            end
            repeat (B) @(negedge clk);
            if (tx !== 1'b1) frame_err++;
            q.push_back(mon_v);
        end
    end
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i[6:0]) + 8'h20;
        mem[0] = 8'h41;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);
        q.delete();
        start = 1'b1;
        bad = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) begin
                chk("fetch_rd_en", rd_en, 1);
                chk("fetch_rd_addr", rd_addr, 0);
                chk("fetch_busy", busy, 1);
            end
            if (n == 2) chk("start_bit_first", tx, 0);
            if (n == 2) chk("rd_en_drop", rd_en, 0);
            if (n == 1 + B) chk("start_bit_last", tx, 0);
            if (n == 2 + B) chk("bit0_of_41", tx, 1);
            if (done === 1'b1) bad++;
        end
        nq = q.size();
        chk("abort_byte_count", nq, 37);
        chk("byte0", q[0], 8'h41);
        chk("byte1", q[1], 8'h21);
        chk("byte36", q[36], 8'h44);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        repeat (2000) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_no_done", bad, 0);
        q.delete();
        frame_err = 0;
        mem[0] = 8'h00;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(mem[i] == 8'h00 ? 8'h20 : mem[i]);
`ifdef DOC_UART_NEWLINE_EN
            if (i % 32 == 31) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
`endif
        end
        start = 1'b1;
        dn = 0;
        for (int n = 1; n <= 60000 && dn == 0; n++) begin
            @(negedge clk);
            start = (n == 4 || n == 25000);
            if (n == 1) begin
                chk("restart_rd_addr", rd_addr, 0);
                chk("restart_rd_en", rd_en, 1);
            end
            if (done === 1'b1) dn = n;
        end
        start = 1'b0;
        chk("done_cycle", dn, EXP_DONE);
        chk("done_busy", busy, 1);
        chk("done_tx", tx, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        nq = q.size();
        chk("byte_count", nq, NBYTES);
        chk("empty_cell_space", q[0], 8'h20);
        chk("cell1", q[1], 8'h21);
`ifdef DOC_UART_NEWLINE_EN
        chk("row_cr", q[32], 8'h0D);
        chk("row_lf", q[33], 8'h0A);
        chk("last_lf", q[575], 8'h0A);
`else
        chk("last_cell", q[511], 8'h9F);
`endif
        bad = 0;
        for (int i = 0; i < NBYTES; i++) if (i >= q.size() || q[i] !== exp_q[i]) bad++;
        chk("stream", bad, 0);
        chk("framing", frame_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/doc_uart_tx.md
Name: doc_uart_tx

Overview:
Downstream consumer of the document RAM's single read port. On a send request it streams all 512 document cells (16 rows x 32 cols, address = {row[3:0], col[4:0]}) out of the board as 8N1 UART. When the last byte is sent it pulses done; that pulse drives the text editor's clear_data, and the editor wipes the document.
Runs in the 25 MHz VGA/document clock domain. It replaces the tied-off UART_out_addr / UART_enable_read / UART_done nets.

Parameters:
CLK_FREQ, 25000000, input clock frequency in Hz
BAUD, 115200, UART bit rate
BIT_CYCLES, CLK_FREQ/BAUD (integer division, 217), clock cycles per UART bit
DOC_DEPTH, 512, number of document cells transmitted
ROW_LEN, 32, cells per document row

Ports:
clk  input  1  25 MHz clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle send request (debounced/one-pulsed send_data)
rd_en  output  1  document read enable (the editor muxes its port address while high)
rd_addr  output  9  document read address
rd_data  input  8  document read data; combinational (distributed RAM), valid in the same cycle as rd_addr
tx  output  1  UART serial line, idle high
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse after the final stop bit

Behaviour:
- Reset values: tx=1, busy=0, done=0, rd_en=0, rd_addr=0. FSM goes to IDLE. Byte index and bit counters are cleared.
- FSM states: IDLE, FETCH, START, DATA, STOP, DONE.
- IDLE: busy=0. When start=1 at a clock edge, the next state is FETCH with idx=0. From that cycle on, busy=1.
- FETCH (1 cycle): rd_en=1, rd_addr=idx. Latch rd_data into the shift register; a value of 0x00 is latched as 0x20 (empty cell sends a space). Next state is START.
- START: tx=0 for BIT_CYCLES cycles.
- DATA: 8 bits, LSB first, each held for BIT_CYCLES cycles.
- STOP: tx=1 for BIT_CYCLES cycles. Then:
  - if idx == DOC_DEPTH-1, go to DONE;
  - otherwise idx <= idx+1 and go to FETCH.
- Each byte occupies exactly 1 + 10*BIT_CYCLES cycles (2171 at the defaults).
- DONE (1 cycle): done=1, busy=1, tx=1. Next state is IDLE.
- The baud counter is 8 bits wide, counts 0..BIT_CYCLES-1, and reloads at every bit boundary. No fractional baud correction.
- rd_en and rd_addr are registered outputs that change only on state transitions. rd_addr holds its last value outside FETCH.
- start while busy=1 (including the DONE cycle) is ignored and is not queued.
- rst together with start: rst wins.
- rst mid-frame: tx=1 from the next cycle, the transfer is aborted, done is never pulsed, and the document is not cleared.
- idx is 9 bits. Wrap from 511 to 0 never happens, because DONE is taken at 511.

Optional Feature:
- Macro DOC_UART_NEWLINE_EN.
- Defined: after the STOP of every byte where idx[4:0]==ROW_LEN-1, two extra frames are sent, 0x0D then 0x0A.
  - Each extra frame takes the normal 1 + 10*BIT_CYCLES cycles. Its pseudo-FETCH cycle has rd_en=0.
  - These frames come before the DONE/next-row decision, so the final row also ends in CR LF.
- Undefined: exactly 512 raw bytes, no extra state or logic.

Test Plan:
- Reset, then hold idle 1000 cycles -> tx=1, busy=0, done=0, rd_en=0 throughout.
- Document cell 0 = 0x41, start pulse at cycle T -> rd_en=1 and rd_addr=0 in cycle T+1; tx=0 during T+2..T+218; bit0=1 at T+219; byte decoded as 0x41 by the bench UART monitor.
- Document filled with cell i = i[6:0]+0x20 -> monitor receives 512 bytes in address order. Cell 0x000 = 0x00 arrives as 0x20. done is high for exactly one cycle, 1,111,553 cycles after the start edge, then busy=0.
- Extra start pulses at cycles +5 and +50000 during a transfer -> ignored; byte count and done timing unchanged.
- rst asserted 3000 cycles into a transfer -> tx=1 next cycle, busy=0, no done pulse. A new start then restarts from rd_addr=0.
- With DOC_UART_NEWLINE_EN -> 576 bytes received; 0x0D 0x0A follow every 32nd cell. done comes 576*2171+1 cycles after start.
